// File: rtl/panel_pkg.sv
// Shared types for the front-panel controller: state and event encodings,
// the button bundle, and the fixed-priority press arbiter.
package panel_pkg;

    localparam int unsigned CNT_W = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DOOR  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE   = 3'd0,
        EV_ON     = 3'd1,
        EV_OFF    = 3'd2,
        EV_ERR    = 3'd3,
        EV_OPEN   = 3'd4,
        EV_BUZZER = 3'd5
    } ev_code_e;

    typedef struct packed {
        logic buzzer;
        logic open;
        logic err;
        logic off;
        logic on;
    } btn_t;

    // Simultaneous presses resolve as err > off > open > on > buzzer.
    function automatic ev_code_e arbitrate(input btn_t press);
        ev_code_e win;
        win = EV_NONE;
        if (press.err)         win = EV_ERR;
        else if (press.off)    win = EV_OFF;
        else if (press.open)   win = EV_OPEN;
        else if (press.on)     win = EV_ON;
        else if (press.buzzer) win = EV_BUZZER;
        return win;
    endfunction

endpackage

// File: rtl/panel_ctrl_beep_timer.sv
// Retriggerable beep timer: a load starts (or restarts) a beep lasting exactly
// BUZZ_CYCLES clocks; the count saturates at zero.
module beep_timer
    import panel_pkg::*;
#(
    parameter int unsigned BUZZ_CYCLES = 25_000_000
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic load,
    output logic active
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(BUZZ_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        active_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel controller: press edge detection, fixed-priority arbitration,
// appliance state machine, LED decode and buzzer drive.
module panel_ctrl
    import panel_pkg::*;
#(
    parameter int unsigned BUZZ_CYCLES = 25_000_000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       on_db,
    input  logic       off_db,
    input  logic       err_db,
    input  logic       open_db,
    input  logic       buzzer_db,
    output logic [1:0] state,
    output logic       run_led,
    output logic       door_led,
    output logic       fault_led,
    output logic       buzzer_out,
    output logic       evt_valid,
    output logic [2:0] evt_code
);

    btn_t     lvl, press, prev_q, prev_d;
    ev_code_e win;
    state_e   state_q, state_d;
    ev_code_e evt_code_q, evt_code_d;
    logic     evt_valid_q, evt_valid_d;
    logic     run_led_q, run_led_d;
    logic     door_led_q, door_led_d;
    logic     fault_led_q, fault_led_d;
    logic     beep_load, beep_clr, beep_rst, beep_active;

    always_comb begin
        lvl         = btn_t'({buzzer_db, open_db, err_db, off_db, on_db});
        press       = btn_t'(lvl & ~prev_q);
        win         = arbitrate(press);
        prev_d      = lvl;
        state_d     = state_q;
        beep_load   = 1'b0;
        beep_clr    = 1'b0;
        evt_valid_d = (win != EV_NONE);
        evt_code_d  = evt_valid_d ? win : evt_code_q;

        if (win == EV_ERR) begin
            state_d  = ST_FAULT;
            beep_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (win == EV_ON)        state_d = ST_RUN;
                    else if (win == EV_OPEN) state_d = ST_DOOR;
                    beep_load = (win == EV_BUZZER);
                end
                ST_RUN: begin
                    if (win == EV_OFF)       state_d = ST_IDLE;
                    else if (win == EV_OPEN) state_d = ST_DOOR;
                    beep_load = (win == EV_BUZZER);
                end
                ST_DOOR: begin
                    if (win == EV_OPEN || win == EV_OFF) state_d = ST_IDLE;
                    // A rejected start while the door is open is announced with a beep.
                    beep_load = (win == EV_BUZZER) || (win == EV_ON);
                end
                ST_FAULT: begin
                    if (win == EV_OFF) state_d = ST_IDLE;
                end
            endcase
        end

        run_led_d   = (state_d == ST_RUN);
        door_led_d  = (state_d == ST_DOOR);
        fault_led_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            prev_q      <= '1;
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b0;
            evt_code_q  <= EV_NONE;
            run_led_q   <= 1'b0;
            door_led_q  <= 1'b0;
            fault_led_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            run_led_q   <= run_led_d;
            door_led_q  <= door_led_d;
            fault_led_q <= fault_led_d;
        end
    end

    // Entering FAULT wipes any beep in progress; FAULT itself holds the buzzer on.
    assign beep_rst = reset | beep_clr;

    beep_timer #(
        .BUZZ_CYCLES(BUZZ_CYCLES)
    ) u_beep_timer (
        .clk_50MHz(clk_50MHz),
        .reset    (beep_rst),
        .load     (beep_load),
        .active   (beep_active)
    );

    assign state      = state_q;
    assign run_led    = run_led_q;
    assign door_led   = door_led_q;
    assign fault_led  = fault_led_q;
    assign buzzer_out = beep_active | fault_led_q;
    assign evt_valid  = evt_valid_q;
    assign evt_code   = evt_code_q;

endmodule

// File: tb/tb_panel_ctrl.sv
// Bench for panel_ctrl: directed scenarios plus random button activity,
// checked against a cycle-level behavioural model and an event scoreboard.
module tb_panel_ctrl;

    localparam int unsigned N = 4;

    logic       clk_50MHz = 1'b0;
    logic       reset     = 1'b1;
    logic       on_db     = 1'b0;
    logic       off_db    = 1'b0;
    logic       err_db    = 1'b0;
    logic       open_db   = 1'b0;
    logic       buzzer_db = 1'b0;
    logic [1:0] state;
    logic       run_led, door_led, fault_led, buzzer_out, evt_valid;
    logic [2:0] evt_code;

    always #10 clk_50MHz = ~clk_50MHz;

    panel_ctrl #(
        .BUZZ_CYCLES(N)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .on_db     (on_db),
        .off_db    (off_db),
        .err_db    (err_db),
        .open_db   (open_db),
        .buzzer_db (buzzer_db),
        .state     (state),
        .run_led   (run_led),
        .door_led  (door_led),
        .fault_led (fault_led),
        .buzzer_out(buzzer_out),
        .evt_valid (evt_valid),
        .evt_code  (evt_code)
    );

    typedef struct {
        int code;
        int st;
    } evt_t;

    evt_t evt_q[$];
    evt_t e;
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference model. Codes: 1 on, 2 off, 3 err, 4 open, 5 buzzer.
    // States: 0 idle, 1 run, 2 door, 3 fault. A beep is tracked as the
    // cycle index at which it ends rather than as a counter.
    int m_state    = 0;
    int m_last     = 0;
    int m_beep_end = 0;
    int cyc        = 0;
    bit m_prev[1:5];
    bit lvl[1:5];
    int win, old_st;
    int prio[5] = '{3, 2, 4, 1, 5};

    always @(posedge clk_50MHz) begin
        cyc++;
        lvl[1] = on_db; lvl[2] = off_db; lvl[3] = err_db; lvl[4] = open_db; lvl[5] = buzzer_db;
        if (reset) begin
            m_state = 0; m_last = 0; m_beep_end = 0;
            for (int i = 1; i <= 5; i++) m_prev[i] = 1'b1;
        end else begin
            win = 0;
            for (int i = 0; i < 5; i++)
                if (win == 0 && lvl[prio[i]] && !m_prev[prio[i]]) win = prio[i];
            for (int i = 1; i <= 5; i++) m_prev[i] = lvl[i];
            if (win != 0) begin
                old_st = m_state;
                if (win == 3) begin
                    m_state = 3;
                    m_beep_end = 0;
                end else begin
                    if ((win == 5 && old_st != 3) || (win == 1 && old_st == 2))
                        m_beep_end = cyc + N;
                    case (old_st)
                        0: if (win == 1) m_state = 1; else if (win == 4) m_state = 2;
                        1: if (win == 2) m_state = 0; else if (win == 4) m_state = 2;
                        2: if (win == 2 || win == 4) m_state = 0;
                        default: if (win == 2) m_state = 0;
                    endcase
                end
                m_last = win;
                evt_q.push_back('{win, m_state});
            end
        end
    end

    // Monitor: drains the scoreboard on each event and checks steady outputs.
    always @(negedge clk_50MHz) begin
        if (cyc > 0) begin
            if (evt_valid) begin
                if (evt_q.size() == 0) begin
                    check("evt_spurious", int'(evt_valid), 0);
                end else begin
                    e = evt_q.pop_front();
                    check("evt_code", int'(evt_code), e.code);
                    check("evt_state", int'(state), e.st);
                end
            end else if (evt_q.size() != 0) begin
                e = evt_q.pop_front();
                check("evt_valid_missing", int'(evt_valid), 1);
            end
            check("state", int'(state), m_state);
            check("run_led", int'(run_led), int'(m_state == 1));
            check("door_led", int'(door_led), int'(m_state == 2));
            check("fault_led", int'(fault_led), int'(m_state == 3));
            check("buzzer_out", int'(buzzer_out), int'((cyc < m_beep_end) || (m_state == 3)));
            check("evt_code_hold", int'(evt_code), m_last);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    // Bit order {buzzer, open, err, off, on}.
    task automatic set_btn(input logic [4:0] v);
        {buzzer_db, open_db, err_db, off_db, on_db} = v;
    endtask

    task automatic press(input logic [4:0] v);
        @(negedge clk_50MHz) set_btn(v);
        @(negedge clk_50MHz) set_btn(5'b0);
    endtask

    logic [4:0] cur;

    initial begin
        // Button held through reset yields no event.
        reset = 1'b1; on_db = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(4);
        on_db = 1'b0;
        wait_cycles(2);

        // on -> RUN, open -> DOOR, rejected on -> beep
        press(5'b00001); wait_cycles(2);
        press(5'b01000); wait_cycles(2);
        press(5'b00001); wait_cycles(8);

        // back to IDLE, RUN, then err+off together -> FAULT, off -> IDLE
        press(5'b01000); wait_cycles(1);
        press(5'b00001); wait_cycles(2);
        press(5'b00110); wait_cycles(4);
        press(5'b10000); wait_cycles(2);
        press(5'b00010); wait_cycles(2);

        // Retriggered beep: two presses two cycles apart
        press(5'b10000);
        press(5'b10000);
        wait_cycles(10);

        // Reset in the middle of a beep
        press(5'b10000); wait_cycles(1);
        reset = 1'b1; wait_cycles(1);
        reset = 1'b0; wait_cycles(6);

        // All five rise together in IDLE
        @(negedge clk_50MHz) set_btn(5'b11111);
        wait_cycles(3);
        set_btn(5'b0); wait_cycles(2);
        press(5'b00010); wait_cycles(2);

        // Random activity
        cur = '0;
        repeat (3000) begin
            @(negedge clk_50MHz);
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
            set_btn(cur);
            reset = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk_50MHz);
        reset = 1'b0;
        set_btn(5'b0);
        wait_cycles(N + 4);

        check("evt_queue_empty", evt_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/panel_ctrl.md
# panel_ctrl

Front-panel controller that sits directly after the five-channel debouncer. It turns the debounced on/off/err/open/buzzer levels into single-cycle press events and arbitrates simultaneous presses by fixed priority. It sequences a four-state appliance state machine and drives a timed buzzer. All outputs are registered and drive the LEDs and buzzer pin.

## Interface
Parameters:
- BUZZ_CYCLES, default 25_000_000, length of one beep in clocks (0.5 s at 50 MHz); legal range 1 to 2^26-1.

Ports:
- clk_50MHz  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- on_db, off_db, err_db, open_db, buzzer_db  in  1 each  debounced button levels (result_on … result_buzzer).
- state  out  2  current state: 0 IDLE, 1 RUN, 2 DOOR, 3 FAULT.
- run_led, door_led, fault_led  out  1 each  one-hot decode of state; IDLE lights none.
- buzzer_out  out  1  buzzer drive.
- evt_valid  out  1  one-cycle pulse for each arbitrated press.
- evt_code  out  3  code of the winning press: 1 on, 2 off, 3 err, 4 open, 5 buzzer. Holds its last value when evt_valid is 0.

## Operation
- Edge detect: each input has a prev register. press = level & ~prev. The prev registers reset to 1, so a button held through reset produces no event.
- Arbitration, for simultaneous presses in the same cycle: err > off > open > on > buzzer. Only the winner is acted on. Losing presses are dropped, not queued.
- State transitions, all taken from the winning press only:
  - err press from any state → FAULT.
  - IDLE: on → RUN; open → DOOR; off and buzzer have no state effect.
  - RUN: off → IDLE; open → DOOR (aborts the run); on is ignored.
  - DOOR: open → IDLE (door closed); off → IDLE; on is rejected and triggers a beep.
  - FAULT: only off → IDLE; every other press is ignored, including buzzer.
- Beep timer: a 26-bit down-counter.
  - Load BUZZ_CYCLES on a buzzer press outside FAULT, or on a rejected on press in DOOR.
  - A new trigger while counting reloads the counter (retrigger).
  - Entering FAULT clears the counter.
- buzzer_out = (counter != 0) | (state == FAULT).
- evt_valid and evt_code update for every winning press, whether or not it has an effect.

## Timing
- Reset values: state = IDLE, all LEDs 0, buzzer_out 0, evt_valid 0, evt_code 0, counter 0, prev = 1.
- Latency: an input that is first sampled high at edge k changes state, the LEDs, evt_* and buzzer_out at edge k. They are visible in cycle k+1, i.e. one clock of latency.
- A beep lasts exactly BUZZ_CYCLES cycles of buzzer_out = 1. With a retrigger, it lasts BUZZ_CYCLES cycles counted from the retrigger edge.
- Counter decrements by 1 per clock, saturates at 0, and never wraps.
- Reset asserted mid-beep or in any state: all registers take their reset values at the next edge, with no residual pulse.
- A level held high produces exactly one press. It can produce another only after it falls and rises again.

## Structure
- Package panel_pkg:
  - state encoding localparams (ST_IDLE…ST_FAULT);
  - event codes (EV_ON…EV_BUZZER);
  - counter width of 26.
- One sub-module, beep_timer:
  - inputs: clk_50MHz, reset, load; parameter BUZZ_CYCLES;
  - output: active.
- Edge detection, arbitration and the FSM live in panel_ctrl.

## Test plan
- Reset with on_db held high, then release reset → no evt_valid; state stays 0.
- BUZZ_CYCLES=4: on rises → next cycle state=1, run_led=1, evt_code=1. Then open rises → state=2. Then on rises → state stays 2, buzzer_out high for exactly 4 cycles.
- err and off rise in the same cycle while in RUN → evt_code=3, state=3, buzzer_out=1 continuously. A later off press → state=0, buzzer_out=0.
- Buzzer press in IDLE, then a second buzzer press 2 cycles later (BUZZ_CYCLES=4) → buzzer_out high for 6 consecutive cycles in total.
- Reset asserted during a beep → buzzer_out=0 and state=0 at the next cycle.
- All five inputs rise together in IDLE → a single evt_valid with evt_code=3, and state=3.
